// File: rtl/sram_arbiter.sv
// Two-port arbiter and sequencer in front of a single-port SRAM with a registered read port.
// Port 0 (fetch) and port 1 (load/store) share the SRAM; read data returns on a per-port strobe.
module sram_arbiter #(
    parameter int ADDRESS_WIDTH  = 15,
    parameter int DATA_WIDTH     = 32,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req0_valid,
    input  logic                     req0_write,
    input  logic [ADDRESS_WIDTH-1:0] req0_address,
    input  logic [DATA_WIDTH-1:0]    req0_data,
    output logic                     req0_ready,
    output logic                     resp0_valid,
    output logic [DATA_WIDTH-1:0]    resp0_data,
    input  logic                     req1_valid,
    input  logic                     req1_write,
    input  logic [ADDRESS_WIDTH-1:0] req1_address,
    input  logic [DATA_WIDTH-1:0]    req1_data,
    output logic                     req1_ready,
    output logic                     resp1_valid,
    output logic [DATA_WIDTH-1:0]    resp1_data,
    output logic                     sram_enable,
    output logic                     sram_readWrite,
    output logic [ADDRESS_WIDTH-1:0] sram_address,
    output logic [DATA_WIDTH-1:0]    sram_dataIn,
    input  logic [DATA_WIDTH-1:0]    sram_dataOut,
    output logic                     busy
);
    // state  | meaning
    // IDLE   | arbitrating, ready offered to the winning port
    // ACCESS | SRAM enabled with the latched command
    // RESP   | SRAM read data valid, captured into the port's response register
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                   state, state_next;
    logic                     last_grant;
    logic                     cmd_write;
    logic                     cmd_port;
    logic [ADDRESS_WIDTH-1:0] cmd_address;
    logic [DATA_WIDTH-1:0]    cmd_data;
    logic                     winner;
    logic                     winner_valid;
    logic                     accept;

    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid) begin
            winner = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant;
        end else if (req1_valid) begin
            winner = 1'b1;
        end
    end

    assign winner_valid = winner ? req1_valid : req0_valid;
    assign accept       = (state == IDLE) && winner_valid && !reset;
    assign req0_ready   = accept && !winner;
    assign req1_ready   = accept && winner;

    always_comb begin
        state_next     = state;
        sram_enable    = 1'b0;
        sram_readWrite = 1'b1;
        case (state)
            IDLE: begin
                if (accept) state_next = ACCESS;
            end
            ACCESS: begin
                // A reset landing in this cycle must not touch the array.
                sram_enable    = !reset;
                sram_readWrite = reset || !cmd_write;
                state_next     = cmd_write ? IDLE : RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign sram_address = cmd_address;
    assign sram_dataIn  = cmd_data;
    assign busy         = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            cmd_write   <= 1'b0;
            cmd_port    <= 1'b0;
            cmd_address <= '0;
            cmd_data    <= '0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            resp0_data  <= '0;
            resp1_data  <= '0;
        end else begin
            state       <= state_next;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            if (accept) begin
                cmd_write   <= winner ? req1_write : req0_write;
                cmd_address <= winner ? req1_address : req0_address;
                cmd_data    <= winner ? req1_data : req0_data;
                cmd_port    <= winner;
                last_grant  <= winner;
            end
            if (state == RESP) begin
                if (cmd_port) begin
                    resp1_valid <= 1'b1;
                    resp1_data  <= sram_dataOut;
                end else begin
                    resp0_valid <= 1'b1;
                    resp0_data  <= sram_dataOut;
                end
            end
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench: SRAM behavioural model, transaction-level reference model, directed and random traffic.
module tb_sram_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req0_write, req0_ready, resp0_valid;
    logic [14:0] req0_address;
    logic [31:0] req0_data, resp0_data;
    logic        req1_valid, req1_write, req1_ready, resp1_valid;
    logic [14:0] req1_address;
    logic [31:0] req1_data, resp1_data;
    logic        sram_enable, sram_readWrite, busy;
    logic [14:0] sram_address;
    logic [31:0] sram_dataIn, sram_dataOut;

    // second instance, fixed priority, write-only traffic
    logic        f_reset, f_v0, f_v1, f_r0, f_r1, f_rv0, f_rv1, f_en, f_rw, f_busy;
    logic [14:0] f_addr;
    logic [31:0] f_rd0, f_rd1, f_din;
    logic [31:0] f_dout = '0;

    logic [31:0] mem     [0:32767];
    logic [31:0] ref_mem [0:32767];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    sram_arbiter #(.ADDRESS_WIDTH(15), .DATA_WIDTH(32), .FIXED_PRIORITY(0)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_address(req0_address),
        .req0_data(req0_data), .req0_ready(req0_ready), .resp0_valid(resp0_valid),
        .resp0_data(resp0_data),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_address(req1_address),
        .req1_data(req1_data), .req1_ready(req1_ready), .resp1_valid(resp1_valid),
        .resp1_data(resp1_data),
        .sram_enable(sram_enable), .sram_readWrite(sram_readWrite), .sram_address(sram_address),
        .sram_dataIn(sram_dataIn), .sram_dataOut(sram_dataOut), .busy(busy)
    );

    sram_arbiter #(.ADDRESS_WIDTH(15), .DATA_WIDTH(32), .FIXED_PRIORITY(1)) dut_fixed (
        .clock(clock), .reset(f_reset),
        .req0_valid(f_v0), .req0_write(1'b1), .req0_address(15'h0001),
        .req0_data(32'h1), .req0_ready(f_r0), .resp0_valid(f_rv0), .resp0_data(f_rd0),
        .req1_valid(f_v1), .req1_write(1'b1), .req1_address(15'h0002),
        .req1_data(32'h2), .req1_ready(f_r1), .resp1_valid(f_rv1), .resp1_data(f_rd1),
        .sram_enable(f_en), .sram_readWrite(f_rw), .sram_address(f_addr),
        .sram_dataIn(f_din), .sram_dataOut(f_dout), .busy(f_busy)
    );

    always @(posedge clock) begin
        if (sram_enable) begin
            if (sram_readWrite) sram_dataOut <= mem[sram_address];
            else                mem[sram_address] <= sram_dataIn;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: occupancy by cycle numbers, a reference memory, one pending command.
    bit          m_on = 1'b0;
    int          m_free, m_acc, m_resp;
    bit          m_last;
    bit          c_wr, c_port, r_port;
    logic [14:0] c_addr;
    logic [31:0] c_data, r_val, e_data0, e_data1;
    int          r0cnt = 0, r1cnt = 0, encnt = 0, bcnt = 0;
    int          glog[$];

    always @(negedge clock) begin
        bit idle, w, e_r0, e_r1, e_en;
        r0cnt += int'(resp0_valid);
        r1cnt += int'(resp1_valid);
        encnt += int'(sram_enable);
        bcnt  += int'(busy);
        if (req0_valid && req0_ready) glog.push_back(0);
        if (req1_valid && req1_ready) glog.push_back(1);
        if (m_on) begin
            if (cyc == m_resp) begin
                if (r_port) e_data1 = r_val; else e_data0 = r_val;
            end
            idle = (cyc >= m_free);
            w    = (req0_valid && req1_valid) ? !m_last : req1_valid;
            e_r0 = idle && !reset && req0_valid && !w;
            e_r1 = idle && !reset && req1_valid && w;
            e_en = (cyc == m_acc) && !reset;
            chk("req0_ready", req0_ready, e_r0);
            chk("req1_ready", req1_ready, e_r1);
            chk("busy", busy, !idle);
            chk("sram_enable", sram_enable, e_en);
            if (e_en) begin
                chk("sram_readWrite", sram_readWrite, !c_wr);
                chk("sram_address", sram_address, c_addr);
                if (c_wr) chk("sram_dataIn", sram_dataIn, c_data);
            end else begin
                chk("sram_readWrite_idle", sram_readWrite, 1'b1);
            end
            chk("resp0_valid", resp0_valid, (cyc == m_resp) && !r_port);
            chk("resp1_valid", resp1_valid, (cyc == m_resp) && r_port);
            chk("resp0_data", resp0_data, e_data0);
            chk("resp1_data", resp1_data, e_data1);
        end
        if (reset) begin
            m_on    = 1'b1;
            m_free  = cyc + 1;
            m_acc   = -1;
            m_resp  = -1;
            m_last  = 1'b1;
            e_data0 = '0;
            e_data1 = '0;
        end else if (m_on) begin
            if (cyc == m_acc) begin
                if (c_wr) ref_mem[c_addr] = c_data;
                else begin
                    r_val  = ref_mem[c_addr];
                    r_port = c_port;
                    m_resp = cyc + 2;
                end
            end
            if (e_r0 || e_r1) begin
                c_port = e_r1;
                c_wr   = e_r1 ? req1_write : req0_write;
                c_addr = e_r1 ? req1_address : req0_address;
                c_data = e_r1 ? req1_data : req0_data;
                m_last = e_r1;
                m_acc  = cyc + 1;
                m_free = cyc + (c_wr ? 2 : 3);
            end
        end
    end

    task automatic do_req(input int port, input bit wr, input logic [14:0] a,
                          input logic [31:0] d, output int acc);
        bit got = 1'b0;
        acc = -1;
        @(posedge clock); #1;
        if (port == 0) begin
            req0_valid = 1'b1; req0_write = wr; req0_address = a; req0_data = d;
        end else begin
            req1_valid = 1'b1; req1_write = wr; req1_address = a; req1_data = d;
        end
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clock);
            if ((port == 0) ? req0_ready : req1_ready) begin
                got = 1'b1;
                acc = cyc;
            end
        end
        chk("req_accepted", got, 1'b1);
        @(posedge clock); #1;
        if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic wait_resp(input int port, output logic [31:0] d, output int rc);
        bit got = 1'b0;
        rc = -1;
        d  = '0;
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clock);
            if ((port == 0) ? resp0_valid : resp1_valid) begin
                got = 1'b1;
                rc  = cyc;
                d   = (port == 0) ? resp0_data : resp1_data;
            end
        end
        chk("resp_seen", got, 1'b1);
    endtask

    task automatic rand_traffic(input int port, input int n);
        int c;
        for (int i = 0; i < n; i++) begin
            logic [14:0] a;
            a = ($urandom_range(0, 7) == 0) ? 15'h7FFF : 15'($urandom_range(0, 7));
            do_req(port, 1'($urandom_range(0, 1)), a, $urandom, c);
            repeat ($urandom_range(0, 3)) @(posedge clock);
        end
    endtask

    initial begin
        int          c0, c1, rc0, rc1, snap_r0, snap_r1, snap_en, snap_b, f_cnt0, f_cnt1;
        logic [31:0] d0, d1;
        reset = 1'b1; f_reset = 1'b1; f_v0 = 1'b0; f_v1 = 1'b0;
        req0_valid = 1'b0; req0_write = 1'b0; req0_address = '0; req0_data = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_address = '0; req1_data = '0;
        for (int i = 0; i < 32768; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // write then read back on port 0
        snap_r1 = r1cnt;
        do_req(0, 1'b1, 15'h0010, 32'h1234_5678, c0);
        do_req(0, 1'b0, 15'h0010, 32'h0, c0);
        wait_resp(0, d0, rc0);
        chk("t1_latency", rc0 - c0, 3);
        chk("t1_data", d0, 32'h1234_5678);
        chk("t1_no_resp1", r1cnt - snap_r1, 0);

        // simultaneous reads straight out of reset
        @(posedge clock); #1 reset = 1'b1;
        mem[1] = 32'hA; ref_mem[1] = 32'hA;
        mem[2] = 32'hB; ref_mem[2] = 32'hB;
        @(posedge clock); #1 reset = 1'b0;
        fork
            begin do_req(0, 1'b0, 15'h0001, 32'h0, c0); wait_resp(0, d0, rc0); end
            begin do_req(1, 1'b0, 15'h0002, 32'h0, c1); wait_resp(1, d1, rc1); end
        join
        chk("t2_port1_after_port0", c1 - c0, 3);
        chk("t2_data0", d0, 32'hA);
        chk("t2_data1", d1, 32'hB);

        // both ports continuously valid: grants alternate
        glog.delete();
        fork
            for (int i = 0; i < 4; i++) do_req(0, 1'b1, 15'($urandom_range(0, 15)), $urandom, c0);
            for (int i = 0; i < 4; i++) do_req(1, 1'b1, 15'($urandom_range(0, 15)), $urandom, c1);
        join
        chk("t3_grant_count", glog.size(), 8);
        for (int i = 0; i < 8 && i < glog.size(); i++) chk("t3_grant_order", glog[i], i % 2);

        // reset during the ACCESS cycle of a port 1 write
        repeat (2) @(posedge clock);
        mem[15'h7FFF] = 32'h0BAD_F00D; ref_mem[15'h7FFF] = 32'h0BAD_F00D;
        snap_r1 = r1cnt;
        do_req(1, 1'b1, 15'h7FFF, 32'hDEAD_BEEF, c1);
        reset = 1'b1;
        @(negedge clock);
        chk("t4_enable_in_reset", sram_enable, 1'b0);
        @(posedge clock); #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        chk("t4_no_resp", r1cnt - snap_r1, 0);
        do_req(0, 1'b0, 15'h7FFF, 32'h0, c0);
        wait_resp(0, d0, rc0);
        chk("t4_old_value", d0, 32'h0BAD_F00D);

        // write and read the top address; busy = ACCESS (write) + ACCESS,RESP (read)
        repeat (2) @(posedge clock);
        snap_b = bcnt;
        do_req(1, 1'b1, 15'h7FFF, 32'hCAFE_F00D, c1);
        do_req(1, 1'b0, 15'h7FFF, 32'h0, c1);
        wait_resp(1, d1, rc1);
        repeat (2) @(posedge clock);
        chk("t5_data", d1, 32'hCAFE_F00D);
        chk("t5_busy_cycles", bcnt - snap_b, 3);

        // idle
        @(negedge clock);
        snap_en = encnt; snap_r0 = r0cnt; snap_r1 = r1cnt;
        repeat (20) @(negedge clock);
        chk("t6_no_enable", encnt - snap_en, 0);
        chk("t6_no_resp0", r0cnt - snap_r0, 0);
        chk("t6_no_resp1", r1cnt - snap_r1, 0);

        // random traffic on both ports, checked by the reference model
        fork
            rand_traffic(0, 40);
            rand_traffic(1, 40);
        join
        repeat (8) @(posedge clock);

        // fixed priority: port 0 takes every grant
        f_cnt0 = 0; f_cnt1 = 0;
        @(posedge clock); #1;
        f_reset = 1'b0; f_v0 = 1'b1; f_v1 = 1'b1;
        repeat (40) begin
            @(negedge clock);
            f_cnt0 += int'(f_r0);
            f_cnt1 += int'(f_r1);
        end
        chk("t3_fixed_port0_grants", f_cnt0, 20);
        chk("t3_fixed_port1_grants", f_cnt1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
